// File: rtl/abr_limb_add_pkg.sv
// Shared types and constants for the limb-serial add/subtract sequencer.
package abr_limb_add_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } abr_limb_add_state_e;

   // Cycles from start acceptance to done_o, on top of NUM_LIMBS.
   localparam int ABR_LIMB_ADD_LAT = 3;

endpackage

// File: rtl/abr_adder.sv
// Single-limb combinational adder with carry in/out.
module abr_adder #(
   parameter int RADIX = 32
) (
   input  logic [RADIX-1:0] a_i,
   input  logic [RADIX-1:0] b_i,
   input  logic             cin_i,
   output logic [RADIX-1:0] s_o,
   output logic             cout_o
);

   always_comb begin
      {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{RADIX{1'b0}}, cin_i};
   end

endmodule

// File: rtl/abr_limb_add_ctrl.sv
// Limb-serial A +/- B sequencer: reads one limb pair per cycle, writes one
// result limb per cycle, carries between limbs through carry_q.
module abr_limb_add_ctrl
   import abr_limb_add_pkg::*;
#(
   parameter int RADIX     = 32,
   parameter int NUM_LIMBS = 8,
   parameter int ADDR_W    = $clog2(NUM_LIMBS)
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              start_i,
   input  logic              sub_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              carry_o,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [RADIX-1:0]  a_limb_i,
   input  logic [RADIX-1:0]  b_limb_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [RADIX-1:0]  wr_data_o
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_LIMBS - 1);

   abr_limb_add_state_e r_state;
   logic              r_sub_q;
   logic              r_carry_q;
   logic              r_drain;
   logic              r_rd_vld;
   logic [ADDR_W-1:0] r_wr_cnt;
   logic              r_busy;
   logic              r_done;
   logic              r_carry_o;
   logic              r_rd_en;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [RADIX-1:0]  r_wr_data;

   logic [RADIX-1:0]  w_b_op;
   logic [RADIX-1:0]  w_sum;
   logic              w_cout;

   // Subtraction runs as A + ~B + 1; the +1 comes from carry_q seeded with sub.
   assign w_b_op = b_limb_i ^ {RADIX{r_sub_q}};

   abr_adder #(.RADIX(RADIX)) u_adder (
      .a_i    (a_limb_i),
      .b_i    (w_b_op),
      .cin_i  (r_carry_q),
      .s_o    (w_sum),
      .cout_o (w_cout)
   );

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_state   <= IDLE;
         r_sub_q   <= 1'b0;
         r_carry_q <= 1'b0;
         r_drain   <= 1'b0;
         r_rd_vld  <= 1'b0;
         r_wr_cnt  <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_carry_o <= 1'b0;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         // Operand memories answer one cycle after the read strobe.
         r_rd_vld <= r_rd_en;
         r_done   <= 1'b0;

         if (r_rd_vld) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= w_sum;
            r_wr_addr <= r_wr_cnt;
            r_wr_cnt  <= (r_wr_cnt == LAST) ? '0 : r_wr_cnt + 1'b1;
            r_carry_q <= w_cout;
         end else begin
            r_wr_en <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_state   <= RUN;
                  r_sub_q   <= sub_i;
                  r_carry_q <= sub_i;
                  r_busy    <= 1'b1;
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= '0;
               end
            end
            RUN: begin
               if (r_rd_addr == LAST) begin
                  r_state   <= DRAIN;
                  r_rd_en   <= 1'b0;
                  r_rd_addr <= '0;
                  r_drain   <= 1'b0;
               end else begin
                  r_rd_addr <= r_rd_addr + 1'b1;
               end
            end
            DRAIN: begin
               // Two cycles: one for the last read data, one for its write.
               if (r_drain) begin
                  r_state   <= DONE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_carry_o <= r_carry_q;
               end else begin
                  r_drain <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign carry_o   = r_carry_o;
   assign rd_en_o   = r_rd_en;
   assign rd_addr_o = r_rd_addr;
   assign wr_en_o   = r_wr_en;
   assign wr_addr_o = r_wr_addr;
   assign wr_data_o = r_wr_data;

endmodule

// File: tb/tb_abr_limb_add_ctrl.sv
// Directed bench for abr_limb_add_ctrl with RADIX=8, NUM_LIMBS=4.
module tb_abr_limb_add_ctrl;
   import abr_limb_add_pkg::*;

   localparam int RADIX     = 8;
   localparam int NUM_LIMBS = 4;
   localparam int ADDR_W    = 2;

   logic              clk = 1'b0;
   logic              rst_b;
   logic              start_i;
   logic              sub_i;
   logic              busy_o;
   logic              done_o;
   logic              carry_o;
   logic              rd_en_o;
   logic [ADDR_W-1:0] rd_addr_o;
   logic [RADIX-1:0]  a_limb_i;
   logic [RADIX-1:0]  b_limb_i;
   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [RADIX-1:0]  wr_data_o;

   abr_limb_add_ctrl #(.RADIX(RADIX), .NUM_LIMBS(NUM_LIMBS), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .start_i   (start_i),
      .sub_i     (sub_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .carry_o   (carry_o),
      .rd_en_o   (rd_en_o),
      .rd_addr_o (rd_addr_o),
      .a_limb_i  (a_limb_i),
      .b_limb_i  (b_limb_i),
      .wr_en_o   (wr_en_o),
      .wr_addr_o (wr_addr_o),
      .wr_data_o (wr_data_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read operand memories.
   logic [RADIX-1:0] mem_a [NUM_LIMBS];
   logic [RADIX-1:0] mem_b [NUM_LIMBS];
   always @(posedge clk) begin
      if (rd_en_o) begin
         a_limb_i <= mem_a[rd_addr_o];
         b_limb_i <= mem_b[rd_addr_o];
      end
   end

   // Result memory and event log, sampled mid-cycle.
   logic [RADIX-1:0] res [NUM_LIMBS];
   int wr_cyc [NUM_LIMBS];
   int nwr, ndone, done_cyc, busy_cnt;
   logic busy_at_done;
   always @(negedge clk) begin
      if (wr_en_o) begin
         res[wr_addr_o]    = wr_data_o;
         wr_cyc[wr_addr_o] = cyc;
         nwr++;
      end
      if (done_o) begin
         ndone++;
         done_cyc     = cyc;
         busy_at_done = busy_o;
      end
      if (busy_o) busy_cnt++;
   end

   int nchk = 0;
   int npass = 0;
   int c0;
   int nwr_snap;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clr_mon();
      nwr = 0; ndone = 0; busy_cnt = 0; done_cyc = -1; busy_at_done = 1'bx;
      for (int i = 0; i < NUM_LIMBS; i++) begin
         res[i]    = 'x;
         wr_cyc[i] = -1;
      end
   endtask

   // Presents start for cycle c0, returns in cycle c0+1 with start dropped.
   task automatic begin_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
      for (int i = 0; i < NUM_LIMBS; i++) begin
         mem_a[i] = a[8*i +: 8];
         mem_b[i] = b[8*i +: 8];
      end
      clr_mon();
      start_i = 1'b1;
      sub_i   = sub;
      c0      = cyc;
      step();
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 40 && ndone == 0; i++) step();
      step();
      check({tag, "_done_seen"}, ndone, 1);
   endtask

   task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic [31:0] exp_res, input logic exp_c);
      begin_op(a, b, sub);
      wait_done(tag);
      check({tag, "_result"}, {res[3], res[2], res[1], res[0]}, exp_res);
      check({tag, "_carry"}, carry_o, exp_c);
      check({tag, "_nwr"}, nwr, NUM_LIMBS);
   endtask

   initial begin
      rst_b = 1'b0; start_i = 1'b0; sub_i = 1'b0;
      a_limb_i = '0; b_limb_i = '0;
      clr_mon();
      repeat (3) step();
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_carry", carry_o, 0);
      check("rst_rd_en", rd_en_o, 0);
      check("rst_rd_addr", rd_addr_o, 0);
      check("rst_wr_en", wr_en_o, 0);
      check("rst_wr_addr", wr_addr_o, 0);
      check("rst_wr_data", wr_data_o, 0);
      rst_b = 1'b1;
      step();

      // 0xFF + 0x01 with full timing checks.
      run_check("add_ff", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
      check("add_ff_done_cyc", done_cyc, c0 + NUM_LIMBS + ABR_LIMB_ADD_LAT);
      check("add_ff_wr0_cyc", wr_cyc[0], c0 + 3);
      check("add_ff_wr1_cyc", wr_cyc[1], c0 + 4);
      check("add_ff_wr3_cyc", wr_cyc[3], c0 + 6);
      check("add_ff_busy_cnt", busy_cnt, NUM_LIMBS + 2);
      check("add_ff_busy_at_done", busy_at_done, 0);

      run_check("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
      run_check("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0);
      run_check("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1);

      // Reset in cycle 4 of an operation.
      begin_op(32'h1111_1111, 32'h2222_2222, 1'b0);
      while (cyc < c0 + 4) step();
      rst_b = 1'b0;
      step();
      check("midrst_wr_en", wr_en_o, 0);
      check("midrst_rd_en", rd_en_o, 0);
      check("midrst_busy", busy_o, 0);
      check("midrst_carry", carry_o, 0);
      step();
      rst_b = 1'b1;
      nwr_snap = nwr;
      repeat (10) step();
      check("midrst_no_done", ndone, 0);
      check("midrst_no_wr", nwr, nwr_snap);
      check("midrst_busy_late", busy_o, 0);
      run_check("post_rst", 32'h8000_0001, 32'h0000_0002, 1'b1, 32'h7FFF_FFFF, 1'b1);

      // Start pulses during RUN and on done_o are ignored; cycle N+4 is accepted.
      begin_op(32'h0102_0304, 32'h1020_3040, 1'b0);
      while (cyc < c0 + 2) step();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      while (cyc < c0 + NUM_LIMBS + 3) step();
      start_i = 1'b1;
      step();
      check("ign_ndone", ndone, 1);
      check("ign_nwr", nwr, NUM_LIMBS);
      check("ign_done_cyc", done_cyc, c0 + NUM_LIMBS + 3);
      check("ign_result", {res[3], res[2], res[1], res[0]}, 32'h1122_3344);
      clr_mon();
      c0 = cyc;
      step();
      start_i = 1'b0;
      wait_done("reacc");
      check("reacc_done_cyc", done_cyc, c0 + NUM_LIMBS + 3);
      check("reacc_nwr", nwr, NUM_LIMBS);
      check("reacc_result", {res[3], res[2], res[1], res[0]}, 32'h1122_3344);
      check("reacc_carry", carry_o, 0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/abr_limb_add_ctrl.md
# abr_limb_add_ctrl

Sequencer that computes wide-operand addition or subtraction, A ± B over NUM_LIMBS limbs of RADIX bits, using a single abr_adder instance, one limb per cycle. It reads operand limbs from two memory read ports and writes result limbs to a memory write port. It propagates the carry (or borrow) between cycles and reports the final carry. It sits between the arithmetic top-level control FSM and the operand/result memories.

## Interface
Parameters:
- RADIX, 32, limb width in bits.
- NUM_LIMBS, 8, limbs per operand; must be ≥ 2.
- ADDR_W, $clog2(NUM_LIMBS), limb address width.

Ports:
- clk, input, 1, single clock; all logic is on the rising edge.
- rst_b, input, 1, reset, synchronous and active-low.
- start_i, input, 1, operation request; accepted only in IDLE.
- sub_i, input, 1, operation select, sampled with start_i: 0 = A+B, 1 = A−B.
- busy_o, output, 1, high from the cycle after acceptance until done_o.
- done_o, output, 1, one-cycle completion pulse.
- carry_o, output, 1, final carry-out. For subtraction, 1 means no borrow (A ≥ B). Held until the next accepted start.
- rd_en_o, output, 1, operand read strobe.
- rd_addr_o, output, ADDR_W, operand limb address, shared by both A and B memories.
- a_limb_i, input, RADIX, A limb; valid one cycle after rd_en_o.
- b_limb_i, input, RADIX, B limb; valid one cycle after rd_en_o.
- wr_en_o, output, 1, result write strobe.
- wr_addr_o, output, ADDR_W, result limb address.
- wr_data_o, output, RADIX, result limb.

## Operation
- Limb 0 is the least significant limb. Reads and writes go in ascending address order.
- FSM states:
  - IDLE to RUN on start_i. On this transition, latch sub_i and load carry_q with sub_i. Subtraction is computed as A + ~B + 1.
  - RUN lasts NUM_LIMBS cycles. Each cycle issues rd_en_o=1 with rd_addr_o = limb counter (0..NUM_LIMBS−1). The last read moves the FSM to DRAIN.
  - DRAIN lasts 2 cycles and completes the pipeline, then moves to DONE.
  - DONE lasts 1 cycle, with done_o=1, then returns to IDLE.
- Datapath:
  - abr_adder inputs are a_i = a_limb_i, b_i = b_limb_i XOR {RADIX{sub_q}}, and cin_i = carry_q.
  - A one-bit read-valid register (rd_en_o delayed by 1) qualifies the adder.
  - When qualified, s_o is registered into wr_data_o, the write address counter drives wr_addr_o, wr_en_o is registered high, and carry_q ← cout_o.
- carry_o is copied from carry_q when entering DONE.
- start_i in any state other than IDLE is ignored; there is no queuing.
- start_i in the same cycle as done_o is ignored. It is accepted from the following cycle (IDLE).
- Arithmetic is modulo 2^(RADIX·NUM_LIMBS). Overflow appears only in carry_o.

## Timing
- Cycle 0 is the cycle in which start_i is accepted in IDLE.
- Reads are issued in cycles 1..N, with addresses 0..N−1.
- Operand data is valid in cycles 2..N+1.
- Writes (wr_en_o=1) occur in cycles 3..N+2, with addresses 0..N−1, one per cycle with no gaps.
- done_o is asserted in cycle N+3. busy_o is high in cycles 1..N+2 and low in cycle N+3.
- Total latency is N+3 cycles. The next start can be accepted in cycle N+4.
- Reset values: all outputs are 0, the FSM is in IDLE, and all counters and carry_q are 0.
- Reset asserted mid-operation: on the next edge, all strobes are 0, the FSM returns to IDLE, and no further reads or writes are issued. Partial results in memory are undefined. carry_o is 0.
- Limb counter and write counter each wrap from N−1 to 0. Neither exceeds N−1 while active.

## Structure
- Package abr_limb_add_pkg holds:
  - typedef enum of the FSM states: IDLE, RUN, DRAIN, DONE;
  - constant ABR_LIMB_ADD_LAT = 3, the cycles added to NUM_LIMBS from start to done.
- Exactly one sub-module: abr_adder #(.RADIX(RADIX)), combinational.
- The FSM, counters, carry register and the output registers are all in this block.

## Test plan
- RADIX=8, N=4, add: A=0x000000FF, B=0x00000001. Required: writes 00,01,00,00 to addresses 0..3 in cycles 3..6, done_o in cycle 7, carry_o=0.
- Add: A=0xFFFFFFFF, B=0x00000001. Required: result 0x00000000, carry_o=1.
- Subtract: A=0x00000005, B=0x00000007. Required: result 0xFFFFFFFE, carry_o=0 (borrow).
- Subtract with equal operands, A=B=0x12345678. Required: result 0x00000000, carry_o=1.
- start_i pulsed in cycles 2 and N+3 of a running operation. Required: both pulses ignored, exactly N writes, a single done_o; a start in cycle N+4 is accepted.
- rst_b driven low in cycle 4 of an operation. Required: from the next edge wr_en_o=0, rd_en_o=0, busy_o=0 and done_o never asserted; the next start after reset produces a correct result.
